// File: rtl/queue_arbiter.sv
// Round-robin arbiter that funnels NUM_REQ requesters into a single queue enqueue port,
// with an optional burst lock that keeps the grant on one requester for up to MAX_BURST beats.
module queue_arbiter #(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned DATA_WIDTH = 4,
    parameter int unsigned MAX_BURST  = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            io_in_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] io_in_data,
    output logic [NUM_REQ-1:0]            io_in_ready,
    output logic                          io_out_valid,
    output logic [DATA_WIDTH-1:0]         io_out_data,
    output logic [$clog2(NUM_REQ)-1:0]    io_out_id,
    input  logic                          io_out_ready,
    output logic [NUM_REQ-1:0]            io_grant,
    output logic                          io_busy
);

    localparam int unsigned IdW     = $clog2(NUM_REQ);
    localparam int unsigned CntW    = 4;
    localparam logic [CntW-1:0] MaxBurstC = CntW'(MAX_BURST);

    typedef enum logic {
        ST_FREE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_e;

    state_e              state_q, state_d;
    logic [IdW-1:0]      owner_q, owner_d;
    logic [CntW-1:0]     burst_cnt_q, burst_cnt_d;
    logic [IdW-1:0]      rr_ptr_q, rr_ptr_d;

    logic [IdW-1:0]      grant_idx;
    logic                found;
    logic [IdW-1:0]      cand;
    logic                owner_valid;
    logic                xfer;
    logic [CntW-1:0]     nb;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_FREE;
            owner_q     <= '0;
            burst_cnt_q <= '0;
            rr_ptr_q    <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            burst_cnt_q <= burst_cnt_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    // Grant selection: a held lock wins while its owner stays valid, else rotate from rr_ptr.
    always_comb begin
        grant_idx   = '0;
        found       = 1'b0;
        cand        = '0;
        owner_valid = io_in_valid[owner_q];
        if (state_q == ST_LOCKED && owner_valid) begin
            grant_idx = owner_q;
            found     = 1'b1;
        end else begin
            for (int unsigned k = 0; k < NUM_REQ; k++) begin
                cand = rr_ptr_q + IdW'(k);
                if (!found && io_in_valid[cand]) begin
                    grant_idx = cand;
                    found     = 1'b1;
                end
            end
        end
    end

    always_comb begin
        io_out_valid = |io_in_valid;
        io_grant     = '0;
        io_out_data  = '0;
        io_out_id    = '0;
        if (io_out_valid) begin
            io_out_id = grant_idx;
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                if (grant_idx == IdW'(i)) begin
                    io_grant[i] = 1'b1;
                    io_out_data = io_in_data[i*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
        io_in_ready = io_grant & {NUM_REQ{io_out_ready}};
        io_busy     = (state_q == ST_LOCKED);
    end

    // Burst accounting: a beat only extends the burst if it came from the lock owner.
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        burst_cnt_d = burst_cnt_q;
        rr_ptr_d    = rr_ptr_q;
        xfer        = io_out_valid && io_out_ready;
        nb          = ((state_q == ST_LOCKED && grant_idx == owner_q) ? burst_cnt_q : CntW'(0))
                      + CntW'(1);
        if (xfer) begin
            rr_ptr_d = grant_idx + IdW'(1);
            if (nb == MaxBurstC) begin
                state_d     = ST_FREE;
                burst_cnt_d = '0;
            end else begin
                state_d     = ST_LOCKED;
                owner_d     = grant_idx;
                burst_cnt_d = nb;
            end
        end else if (state_q == ST_LOCKED && !owner_valid) begin
            state_d     = ST_FREE;
            burst_cnt_d = '0;
        end
    end

endmodule

// File: tb/tb_queue_arbiter.sv
// Directed bench for queue_arbiter: a burst-2 instance driven from a vector table plus
// hand sequences for async reset, and a burst-1 instance checked for pure round-robin.
module tb_queue_arbiter;

    logic        clk;
    logic        reset;
    logic [3:0]  v0, v1;
    logic [15:0] d0, d1;
    logic        r0, r1;
    logic [3:0]  ir0, ir1, g0, g1;
    logic        ov0, ov1, b0, b1;
    logic [3:0]  od0, od1;
    logic [1:0]  id0, id1;

    int total = 0;
    int bad   = 0;

    queue_arbiter #(.NUM_REQ(4), .DATA_WIDTH(4), .MAX_BURST(2)) u0 (
        .clk(clk), .reset(reset), .io_in_valid(v0), .io_in_data(d0), .io_in_ready(ir0),
        .io_out_valid(ov0), .io_out_data(od0), .io_out_id(id0), .io_out_ready(r0),
        .io_grant(g0), .io_busy(b0)
    );

    queue_arbiter #(.NUM_REQ(4), .DATA_WIDTH(4), .MAX_BURST(1)) u1 (
        .clk(clk), .reset(reset), .io_in_valid(v1), .io_in_data(d1), .io_in_ready(ir1),
        .io_out_valid(ov1), .io_out_data(od1), .io_out_id(id1), .io_out_ready(r1),
        .io_grant(g1), .io_busy(b1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] valid;
        logic       rdy;
        logic [1:0] id;
        logic       busy;
    } vec_t;

    vec_t vec [24];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Full output check of instance u0 against an expected id/busy for the current inputs.
    task automatic chk_u0(input string tag, input logic [1:0] id, input logic busy);
        logic       ev;
        logic [3:0] eg, edat;
        ev   = |v0;
        eg   = ev ? (4'b0001 << id) : 4'b0000;
        edat = ev ? (4'hA + 4'(id)) : 4'h0;
        chk({tag, " out_valid"}, 32'(ov0), 32'(ev));
        chk({tag, " out_id"},    32'(id0), ev ? 32'(id) : 32'd0);
        chk({tag, " grant"},     32'(g0),  32'(eg));
        chk({tag, " out_data"},  32'(od0), 32'(edat));
        chk({tag, " in_ready"},  32'(ir0), r0 ? 32'(eg) : 32'd0);
        chk({tag, " busy"},      32'(b0),  32'(busy));
    endtask

    initial begin
        vec[0]  = '{4'hF, 1'b1, 2'd0, 1'b0};
        vec[1]  = '{4'hF, 1'b1, 2'd0, 1'b1};
        vec[2]  = '{4'hF, 1'b1, 2'd1, 1'b0};
        vec[3]  = '{4'hF, 1'b1, 2'd1, 1'b1};
        vec[4]  = '{4'hF, 1'b1, 2'd2, 1'b0};
        vec[5]  = '{4'hF, 1'b1, 2'd2, 1'b1};
        vec[6]  = '{4'hF, 1'b1, 2'd3, 1'b0};
        vec[7]  = '{4'hF, 1'b1, 2'd3, 1'b1};
        vec[8]  = '{4'hF, 1'b1, 2'd0, 1'b0};
        vec[9]  = '{4'h0, 1'b1, 2'd0, 1'b1};
        vec[10] = '{4'h0, 1'b0, 2'd0, 1'b0};
        vec[11] = '{4'h4, 1'b0, 2'd2, 1'b0};
        vec[12] = '{4'h4, 1'b0, 2'd2, 1'b0};
        vec[13] = '{4'h4, 1'b0, 2'd2, 1'b0};
        vec[14] = '{4'h4, 1'b1, 2'd2, 1'b0};
        vec[15] = '{4'h4, 1'b1, 2'd2, 1'b1};
        vec[16] = '{4'h4, 1'b1, 2'd2, 1'b0};
        vec[17] = '{4'h4, 1'b0, 2'd2, 1'b1};
        vec[18] = '{4'h4, 1'b1, 2'd2, 1'b1};
        vec[19] = '{4'h0, 1'b0, 2'd0, 1'b0};
        vec[20] = '{4'h2, 1'b1, 2'd1, 1'b0};
        vec[21] = '{4'h8, 1'b1, 2'd3, 1'b1};
        vec[22] = '{4'h9, 1'b1, 2'd3, 1'b1};
        vec[23] = '{4'h9, 1'b1, 2'd0, 1'b0};

        reset = 1'b0;
        d0 = 16'hDCBA; d1 = 16'hDCBA;
        v0 = 4'hF; r0 = 1'b1;
        v1 = 4'h0; r1 = 1'b0;
        #1;
        chk_u0("reset", 2'd0, 1'b0);
        repeat (2) @(posedge clk);
        chk_u0("reset_held", 2'd0, 1'b0);
        #1 reset = 1'b1;

        for (int i = 0; i < 24; i++) begin
            v0 = vec[i].valid;
            r0 = vec[i].rdy;
            @(negedge clk);
            chk_u0($sformatf("vec%0d", i), vec[i].id, vec[i].busy);
            @(posedge clk);
            #1;
        end

        // Lock held by 0 is forfeited; requester 2 starts a burst (owner=2, cnt=1).
        v0 = 4'h4; r0 = 1'b1;
        @(negedge clk);
        chk_u0("pre_rst", 2'd2, 1'b1);
        @(posedge clk);
        #1;
        chk("pre_rst busy", 32'(b0), 32'd1);
        #2;
        v0 = 4'hF;
        reset = 1'b0;
        #1;
        chk_u0("async_rst", 2'd0, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk_u0("post_rst", 2'd0, 1'b0);
        @(posedge clk);
        #1;
        chk_u0("post_rst_beat", 2'd0, 1'b1);

        // Pure round-robin instance.
        v0 = 4'h0; r0 = 1'b0;
        v1 = 4'hA; r1 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk($sformatf("rr%0d id", i),    32'(id1),  (i % 2 == 0) ? 32'd1 : 32'd3);
            chk($sformatf("rr%0d grant", i), 32'(g1),   (i % 2 == 0) ? 32'h2 : 32'h8);
            chk($sformatf("rr%0d data", i),  32'(od1),  (i % 2 == 0) ? 32'hB : 32'hD);
            chk($sformatf("rr%0d busy", i),  32'(b1),   32'd0);
            @(posedge clk);
            #1;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
